subtractor_share_arbiter: RTL

- Shares one signed subtractor datapath among NUM_REQ requesters using round-robin arbitration, valid/ready handshakes and one registered result slot.
- Used where several pipeline lanes (e.g. I/Q offset or phase-difference lanes) each need an occasional signed difference and a subtractor per lane is too costly in area/power.
- Result is tagged with the requester index so downstream logic can route it.

---
 rtl/subtractor_share_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/subtractor_share_arbiter.sv
// subtractor_share_arbiter: round-robin shared signed subtractor with one registered result slot
module subtractor_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_IN_WIDTH  = 8,
    parameter int DATA_OUT_WIDTH = 8,
    parameter bit TAKE_MSB       = 1'b1,
    parameter int ID_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]   req_data_1,
    input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]   req_data_2,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [DATA_OUT_WIDTH-1:0]          resp_data,
    output logic [ID_WIDTH-1:0]                resp_id,
    output logic [CNT_WIDTH-1:0]               op_count
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t                          state_q;
    logic [ID_WIDTH-1:0]             rr_q, rr_d, grant, idx, id_q;
    logic                            any_valid, can_accept, accept;
    logic signed [DATA_IN_WIDTH-1:0] a, b;
    logic signed [DATA_IN_WIDTH:0]   diff;
    logic [DATA_OUT_WIDTH-1:0]       data_q, data_d;
    logic [CNT_WIDTH-1:0]            cnt_q;
    // Walk from the far end back toward rr_q so the closest valid requester wins.
    always_comb begin
        grant = '0;
        idx = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_WIDTH'((int'(rr_q) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                grant = idx;
                any_valid = 1'b1;
            end
        end
    end
    always_comb begin
        a = '0;
        b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == grant) begin
                a = req_data_1[i*DATA_IN_WIDTH +: DATA_IN_WIDTH];
                b = req_data_2[i*DATA_IN_WIDTH +: DATA_IN_WIDTH];
            end
        end
    end
    assign diff       = (DATA_IN_WIDTH+1)'(a) - (DATA_IN_WIDTH+1)'(b);
    assign data_d     = TAKE_MSB ? diff[DATA_IN_WIDTH -: DATA_OUT_WIDTH] : diff[DATA_OUT_WIDTH-1:0];
    assign rr_d       = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
    assign can_accept = (state_q == EMPTY) || resp_ready;
    assign req_ready  = (!rst && can_accept && any_valid) ? (NUM_REQ'(1) << grant) : '0;
    assign accept     = |(req_valid & req_ready);
    assign resp_valid = (state_q == FULL);
    assign resp_data  = data_q;
    assign resp_id    = id_q;
    assign op_count   = cnt_q;
    // A drain and an accept on the same edge leave the slot FULL with the new result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            if (state_q == FULL && resp_ready) begin
                cnt_q   <= cnt_q + 1'b1;
                state_q <= EMPTY;
            end
            if (accept) begin
                state_q <= FULL;
                data_q  <= data_d;
                id_q    <= grant;
                rr_q    <= rr_d;
            end
        end
    end
endmodule
